fifo_ptr_ctrl: RTL

Pointer and occupancy controller for a single-clock FIFO whose storage is an external register file or RAM of exactly Depth entries. It arbitrates the ready/valid handshakes on the write and read sides and produces write/read enables and addresses. It maintains full, empty, occupancy and watermark status. Depth need not be a power of two; pointers wrap at Depth-1 using width-cast constant compares.

---
 rtl/fifo_ptr_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and watermark controller for a single-clock FIFO with
// external storage of exactly Depth entries (Depth need not be a power of two).
module fifo_ptr_ctrl #(
    parameter int Depth    = 5,
    parameter int WmThresh = 4,
    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic                wr_en_o,
    output logic [PtrWidth-1:0] wr_addr_o,
    output logic [PtrWidth-1:0] rd_addr_o,
    output logic                rd_pop_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] depth_o,
    output logic                wm_o,
    output logic                err_o
);

    // One extra bit so the pointer-derived occupancy can exceed Depth when corrupted.
    localparam int OccWidth = CntWidth + 1;

    logic [PtrWidth-1:0] wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
    logic [PtrWidth-1:0] wptr_inc_s, rptr_inc_s;
    logic                wphase_r, rphase_r, wphase_nxt_s, rphase_nxt_s;
    logic                wwrap_s, rwrap_s;
    logic [CntWidth-1:0] depth_r, depth_nxt_s;
    logic                wm_r, wm_nxt_s;
    logic                err_r, err_nxt_s;
    logic                full_s, empty_s, wr_en_s, rd_pop_s;
    logic [OccWidth-1:0] occ_s;

    if (Depth < 1 || Depth > 65535) begin : g_bad_depth
        $error("fifo_ptr_ctrl: Depth must be in 1..65535");
    end
    if (WmThresh < 1 || WmThresh > Depth) begin : g_bad_wm
        $error("fifo_ptr_ctrl: WmThresh must be in 1..Depth");
    end

    // With a single entry the pointers never move; only the phase bits toggle.
    if (Depth == 1) begin : g_single
        assign wwrap_s    = 1'b1;
        assign rwrap_s    = 1'b1;
        assign wptr_inc_s = '0;
        assign rptr_inc_s = '0;
    end else begin : g_multi
        assign wwrap_s    = (wptr_r == PtrWidth'(Depth - 1));
        assign rwrap_s    = (rptr_r == PtrWidth'(Depth - 1));
        assign wptr_inc_s = wwrap_s ? '0 : (wptr_r + PtrWidth'(1));
        assign rptr_inc_s = rwrap_s ? '0 : (rptr_r + PtrWidth'(1));
    end

    assign empty_s  = (wptr_r == rptr_r) && (wphase_r == rphase_r);
    assign full_s   = (wptr_r == rptr_r) && (wphase_r != rphase_r);
    assign wr_en_s  = wvalid_i & ~full_s & ~clr_i;
    assign rd_pop_s = rready_i & ~empty_s & ~clr_i;

    // Occupancy implied by pointers and phases, used only for the consistency check.
    always_comb begin
        occ_s = '0;
        if (wphase_r == rphase_r) begin
            occ_s = OccWidth'(wptr_r) - OccWidth'(rptr_r);
        end else begin
            occ_s = OccWidth'(Depth) + OccWidth'(wptr_r) - OccWidth'(rptr_r);
        end
    end

    // Next-state for pointers, phases, occupancy, watermark and sticky error.
    always_comb begin
        wptr_nxt_s   = wptr_r;
        rptr_nxt_s   = rptr_r;
        wphase_nxt_s = wphase_r;
        rphase_nxt_s = rphase_r;
        depth_nxt_s  = depth_r;
        err_nxt_s    = err_r | (occ_s != {1'b0, depth_r})
                             | ({1'b0, depth_r} > OccWidth'(Depth));
        if (clr_i) begin
            wptr_nxt_s   = '0;
            rptr_nxt_s   = '0;
            wphase_nxt_s = 1'b0;
            rphase_nxt_s = 1'b0;
            depth_nxt_s  = '0;
        end else begin
            if (wr_en_s) begin
                wptr_nxt_s   = wptr_inc_s;
                wphase_nxt_s = wphase_r ^ wwrap_s;
            end else begin
                wptr_nxt_s   = wptr_r;
                wphase_nxt_s = wphase_r;
            end
            if (rd_pop_s) begin
                rptr_nxt_s   = rptr_inc_s;
                rphase_nxt_s = rphase_r ^ rwrap_s;
            end else begin
                rptr_nxt_s   = rptr_r;
                rphase_nxt_s = rphase_r;
            end
            case ({wr_en_s, rd_pop_s})
                2'b10:   depth_nxt_s = depth_r + CntWidth'(1);
                2'b01:   depth_nxt_s = depth_r - CntWidth'(1);
                default: depth_nxt_s = depth_r;
            endcase
        end
        wm_nxt_s = (depth_nxt_s >= CntWidth'(WmThresh));
    end

    // State register; reset wins over flush and handshakes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_r   <= '0;
            rptr_r   <= '0;
            wphase_r <= 1'b0;
            rphase_r <= 1'b0;
            depth_r  <= '0;
            wm_r     <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            wptr_r   <= wptr_nxt_s;
            rptr_r   <= rptr_nxt_s;
            wphase_r <= wphase_nxt_s;
            rphase_r <= rphase_nxt_s;
            depth_r  <= depth_nxt_s;
            wm_r     <= wm_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    assign wready_o  = ~full_s;
    assign rvalid_o  = ~empty_s;
    assign full_o    = full_s;
    assign empty_o   = empty_s;
    assign wr_en_o   = wr_en_s;
    assign rd_pop_o  = rd_pop_s;
    assign wr_addr_o = wptr_r;
    assign rd_addr_o = rptr_r;
    assign depth_o   = depth_r;
    assign wm_o      = wm_r;
    assign err_o     = err_r;

endmodule
